// File: rtl/pe_pkg.sv
// pe_pkg: shared widths, rounding constant and default pipeline payload for the MAC bank PE.
package pe_pkg;
  localparam int DEF_INT_BITS = 7;
  localparam int DEF_FRAC_BITS = 9;
  localparam int DEF_NUM_ACC = 8;
  localparam int DEF_ACC_GUARD = 4;
  localparam bit DEF_SAT_EN = 1'b1;
  function automatic int calc_w(int ib, int fb);
    return ib + fb;
  endfunction
  function automatic int calc_aw(int ib, int fb, int g);
    return 2 * (ib + fb) + g;
  endfunction
  function automatic int calc_iw(int n);
    return $clog2(n);
  endfunction
  function automatic longint round_half(int fb);
    return longint'(1) << (fb - 1);
  endfunction
  localparam int W = calc_w(DEF_INT_BITS, DEF_FRAC_BITS);
  localparam int AW = calc_aw(DEF_INT_BITS, DEF_FRAC_BITS, DEF_ACC_GUARD);
  localparam int IW = calc_iw(DEF_NUM_ACC);
  localparam longint ROUND_HALF = round_half(DEF_FRAC_BITS);
  typedef struct packed {
    logic signed [2*W-1:0] prod;
    logic [IW-1:0] idx;
    logic last;
    logic valid;
  } pe_pipe_t;
endpackage

// File: rtl/pe_mac_bank_if.sv
// pe_mac_bank_if: operand and result handshakes of the MAC bank PE, plus the bank-clear strobe.
interface pe_mac_bank_if #(parameter int W = 16, parameter int IW = 3);
  logic in_valid;
  logic in_ready;
  logic signed [W-1:0] in_a;
  logic signed [W-1:0] in_b;
  logic [IW-1:0] in_idx;
  logic in_last;
  logic clr_all;
  logic out_valid;
  logic out_ready;
  logic [W-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic out_sat;
  modport slave (
    input in_valid, in_a, in_b, in_idx, in_last, clr_all, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_sat
  );
  modport master (
    output in_valid, in_a, in_b, in_idx, in_last, clr_all, out_ready,
    input in_ready, out_valid, out_data, out_idx, out_sat
  );
endinterface

// File: rtl/pe_round_sat.sv
// pe_round_sat: round-half-up an accumulator sum to the W-bit result format, saturating or wrapping.
module pe_round_sat
  import pe_pkg::*;
#(
  parameter int INT_BITS = DEF_INT_BITS,
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int ACC_GUARD = DEF_ACC_GUARD,
  parameter bit SAT_EN = DEF_SAT_EN
) (
  input  logic signed [calc_aw(INT_BITS, FRAC_BITS, ACC_GUARD)-1:0] i_sum,
  output logic [calc_w(INT_BITS, FRAC_BITS)-1:0] o_data,
  output logic o_sat
);
  localparam int RW = calc_w(INT_BITS, FRAC_BITS);
  localparam int RAW = calc_aw(INT_BITS, FRAC_BITS, ACC_GUARD);
  localparam logic signed [RAW:0] HALF = (RAW+1)'(round_half(FRAC_BITS));
  logic signed [RAW:0] w_biased;
  logic signed [RAW:0] w_shift;
  logic w_fit;
  // one extra bit so the rounding bias cannot wrap the sum
  assign w_biased = $signed({i_sum[RAW-1], i_sum}) + HALF;
  assign w_shift = w_biased >>> FRAC_BITS;
  assign w_fit = (&w_shift[RAW:RW-1]) | ~(|w_shift[RAW:RW-1]);
  assign o_sat = ~w_fit;
  assign o_data = (SAT_EN && !w_fit) ? (w_shift[RAW] ? {1'b1, {(RW-1){1'b0}}} : {1'b0, {(RW-1){1'b1}}})
                                     : w_shift[RW-1:0];
endmodule

// File: rtl/pe_mac_bank.sv
// pe_mac_bank: pipelined signed fixed-point MAC into selectable accumulator banks,
// with rounding/saturation and valid/ready on both sides; the whole pipe holds on output stall.
module pe_mac_bank
  import pe_pkg::*;
#(
  parameter int INT_BITS = DEF_INT_BITS,
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int NUM_ACC = DEF_NUM_ACC,
  parameter int ACC_GUARD = DEF_ACC_GUARD,
  parameter bit SAT_EN = DEF_SAT_EN
) (
  input logic clk,
  input logic rst_n,
  pe_mac_bank_if.slave bus
);
  localparam int PW = calc_w(INT_BITS, FRAC_BITS);
  localparam int PAW = calc_aw(INT_BITS, FRAC_BITS, ACC_GUARD);
  localparam int PIW = calc_iw(NUM_ACC);
  typedef struct packed {
    logic signed [2*PW-1:0] prod;
    logic [PIW-1:0] idx;
    logic last;
    logic valid;
  } pipe_t;
  pipe_t r_s1;
  logic signed [PAW-1:0] r_acc [NUM_ACC];
  logic signed [PAW-1:0] r_rnd_sum;
  logic [PIW-1:0] r_rnd_idx;
  logic r_rnd_valid;
  logic r_out_valid;
  logic [PW-1:0] r_out_data;
  logic [PIW-1:0] r_out_idx;
  logic r_out_sat;
  logic w_stall;
  logic signed [2*PW-1:0] w_prod;
  logic signed [PAW-1:0] w_sum;
  logic [PW-1:0] w_rs_data;
  logic w_rs_sat;
  assign w_stall = r_out_valid && !bus.out_ready;
  assign w_prod = bus.in_a * bus.in_b;
  assign w_sum = r_acc[r_s1.idx] + {{ACC_GUARD{r_s1.prod[2*PW-1]}}, r_s1.prod};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_s1 <= '0;
    else if (bus.clr_all) r_s1.valid <= 1'b0;
    else if (!w_stall) r_s1 <= '{prod: w_prod, idx: bus.in_idx, last: bus.in_last, valid: bus.in_valid};
  end
  // read-modify-write of the bank happens in one cycle, so same-bank beats need no forwarding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < NUM_ACC; i++) r_acc[i] <= '0;
    else if (bus.clr_all) for (int i = 0; i < NUM_ACC; i++) r_acc[i] <= '0;
    else if (!w_stall && r_s1.valid) r_acc[r_s1.idx] <= r_s1.last ? '0 : w_sum;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rnd_valid <= 1'b0;
      r_rnd_sum <= '0;
      r_rnd_idx <= '0;
    end else if (!w_stall) begin
      r_rnd_valid <= r_s1.valid && r_s1.last && !bus.clr_all;
      if (r_s1.valid && r_s1.last) begin
        r_rnd_sum <= w_sum;
        r_rnd_idx <= r_s1.idx;
      end
    end
  end
  pe_round_sat #(
    .INT_BITS(INT_BITS), .FRAC_BITS(FRAC_BITS), .ACC_GUARD(ACC_GUARD), .SAT_EN(SAT_EN)
  ) u_round (
    .i_sum(r_rnd_sum), .o_data(w_rs_data), .o_sat(w_rs_sat)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data <= '0;
      r_out_idx <= '0;
      r_out_sat <= 1'b0;
    end else if (!w_stall) begin
      r_out_valid <= r_rnd_valid;
      if (r_rnd_valid) begin
        r_out_data <= w_rs_data;
        r_out_idx <= r_rnd_idx;
        r_out_sat <= w_rs_sat;
      end
    end
  end
  assign bus.in_ready = !w_stall;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data = r_out_data;
  assign bus.out_idx = r_out_idx;
  assign bus.out_sat = r_out_sat;
endmodule

// File: tb/tb_pe_mac_bank.sv
// tb_pe_mac_bank: directed vectors for pe_mac_bank; expected results queue up at issue
// and a monitor pops them whenever the DUT hands a result over.
module tb_pe_mac_bank;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  pe_mac_bank_if #(.W(16), .IW(3)) bus ();
  pe_mac_bank dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [15:0] d;
    logic [2:0] i;
    logic s;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  task automatic chk(string n, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, req);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_result actual=%h required=none", bus.out_data);
      end else begin
        e = q.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(e.d));
        chk("out_idx", 32'(bus.out_idx), 32'(e.i));
        chk("out_sat", 32'(bus.out_sat), 32'(e.s));
      end
    end
  end
  task automatic beat(logic [15:0] a, logic [15:0] b, logic [2:0] idx, logic last);
    int n = 0;
    logic acc;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_idx = idx;
    bus.in_last = last;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL beat_accept actual=timeout required=accepted");
    end
    bus.in_valid = 1'b0;
  endtask
  task automatic res(logic [15:0] a, logic [15:0] b, logic [2:0] idx, logic [15:0] d, logic s);
    q.push_back('{d: d, i: idx, s: s});
    beat(a, b, idx, 1'b1);
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d_pending required=0", q.size());
      q.delete();
    end
  endtask
  task automatic wait_valid();
    int n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wait_out_valid", 32'(bus.out_valid), 32'd1);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_idx = '0;
    bus.in_last = 1'b0;
    bus.clr_all = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_idx", 32'(bus.out_idx), 32'd0);
    chk("rst_out_sat", 32'(bus.out_sat), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    // single beat, then bank 2 must have been cleared
    res(16'h0300, 16'h0400, 3'd2, 16'h0600, 1'b0);
    drain();
    res(16'h0200, 16'h0200, 3'd2, 16'h0200, 1'b0);
    drain();
    // interleaved accumulation on banks 3 and 5
    beat(16'h0200, 16'h0200, 3'd3, 1'b0);
    beat(16'h0200, 16'h0100, 3'd5, 1'b0);
    beat(16'h0200, 16'h0200, 3'd3, 1'b0);
    beat(16'h0200, 16'h0100, 3'd5, 1'b0);
    beat(16'h0200, 16'h0200, 3'd3, 1'b0);
    res(16'h0200, 16'h0200, 3'd3, 16'h0800, 1'b0);
    res(16'h0200, 16'h0200, 3'd5, 16'h0400, 1'b0);
    drain();
    // saturation and rounding ties, back to back
    res(16'h7800, 16'h7800, 3'd0, 16'h7FFF, 1'b1);
    res(16'hC000, 16'h1000, 3'd1, 16'h8000, 1'b1);
    res(16'h0001, 16'h0100, 3'd6, 16'h0001, 1'b0);
    res(16'hFFFF, 16'h0100, 3'd7, 16'h0000, 1'b0);
    drain();
    // backpressure
    bus.out_ready = 1'b0;
    res(16'h0300, 16'h0400, 3'd0, 16'h0600, 1'b0);
    res(16'h0200, 16'h0200, 3'd1, 16'h0200, 1'b0);
    res(16'h0100, 16'h0200, 3'd2, 16'h0100, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_out_data", 32'(bus.out_data), 32'h0600);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_rate", 32'(bus.out_valid), (i < 3) ? 32'd1 : 32'd0);
    end
    drain();
    // clear one cycle after a non-last beat
    beat(16'h0200, 16'h0200, 3'd1, 1'b0);
    bus.clr_all = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_all = 1'b0;
    beat(16'h0200, 16'h0100, 3'd1, 1'b0);
    res(16'h0200, 16'h0200, 3'd1, 16'h0300, 1'b0);
    drain();
    // async reset with partial sums and a stalled result
    beat(16'h0200, 16'h0200, 3'd4, 1'b0);
    beat(16'h0200, 16'h0200, 3'd4, 1'b0);
    bus.out_ready = 1'b0;
    beat(16'h0200, 16'h0200, 3'd6, 1'b1);
    wait_valid();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_out_data", 32'(bus.out_data), 32'd0);
    @(negedge clk);
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    res(16'h0200, 16'h0200, 3'd4, 16'h0200, 1'b0);
    res(16'h0200, 16'h0200, 3'd6, 16'h0200, 1'b0);
    drain();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pe_mac_bank.md
Name: pe_mac_bank

Overview:
- Parametrised successor PE: signed fixed-point multiply-accumulate into NUM_ACC selectable accumulator banks.
- Rounding, optional saturation and a valid/ready handshake on both sides.
- Sits in the PE array between the operand broadcast network and the result collector.
- Replaces the fixed 16-bit, 8-bank, handshake-free PE.

Parameters:
- INT_BITS, 7, integer bits of operand/result format (incl. sign); W = INT_BITS+FRAC_BITS
- FRAC_BITS, 9, fractional bits of operand/result format
- NUM_ACC, 8, number of accumulator banks (>=2); IW = $clog2(NUM_ACC)
- ACC_GUARD, 4, guard bits; accumulator width AW = 2W+ACC_GUARD
- SAT_EN, 1, 1 = saturate result to W-bit signed range, 0 = wrap (truncate MSBs)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  PE can accept a beat
- in_a  in  W  signed Q(INT_BITS.FRAC_BITS) operand
- in_b  in  W  signed operand
- in_idx  in  IW  target accumulator bank
- in_last  in  1  final beat of the bank's sum: emit result, then clear bank
- clr_all  in  1  synchronous clear of all banks and in-flight beats
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  W  rounded, saturated result
- out_idx  out  IW  bank that produced out_data
- out_sat  out  1  saturation/overflow occurred for this result

Behaviour:
- Reset (async, rst_n=0):
  - all banks, pipeline valids and output regs go to 0
  - out_valid=0, out_data=0, out_idx=0, out_sat=0
  - in_ready=1 in the cycle after release
  - Reset mid-operation discards all in-flight beats and partial sums.
- Handshake:
  - Beat accepted at edge E0 when in_valid && in_ready.
  - Output is consumed when out_valid && out_ready.
  - out_* stay stable while out_valid && !out_ready.
- Stall:
  - stall = out_valid && !out_ready; in_ready = !stall.
  - While stall is high, every pipeline stage holds.
- S1 (E0): product register = in_a*in_b, full 2W signed; idx and last are registered alongside.
- S2 (E1):
  - sum = acc[idx] + sign-extend(product), computed in AW bits with wrap.
  - If !last: acc[idx] <= sum.
  - If last: acc[idx] <= 0, and sum plus idx are loaded into the round register.
- Back-to-back beats to the same idx need no forwarding: the read and write are in the same cycle of S2. Different idx values may interleave freely.
- S3 (E2):
  - r = (sum + 2^(FRAC_BITS-1)) >>> FRAC_BITS, i.e. round-half-up (toward +inf on ties).
  - SAT_EN=1: clamp r to [-2^(W-1), 2^(W-1)-1], out_sat=1 if clamped.
  - SAT_EN=0: take the low W bits; out_sat=1 if the discarded bits are not a sign extension.
  - out_valid=1.
  - Latency: last beat accepted at E0 gives out_valid high after E2 (3 edges, no stall).
- Output slot: a new result may load at the same edge as the consumer's handshake. Throughput is 1 result per cycle.
- clr_all:
  - At its edge, all banks <= 0 and S1/S2 valids <= 0.
  - The round stage and a pending output are kept.
  - in_ready stays as given by stall; a beat accepted in the same cycle as clr_all is dropped.
  - clr_all has priority over any S2 write in that cycle.
- Bank sum overflowing AW wraps silently. This is not flagged beyond out_sat at rounding.

Decomposition:
- Package pe_pkg:
  - localparams or functions for W, AW, IW derived from the parameters
  - the ROUND_HALF constant
  - a typedef struct of the S1/S2 pipeline payload: product, idx, last, valid
- Sub-module pe_round_sat: purely combinational, AW in to W out, plus a sat flag, parametrised by INT_BITS, FRAC_BITS, ACC_GUARD, SAT_EN.
- The rest of the logic (pipeline, banks, stall) stays in pe_mac_bank.

Test Plan (defaults, 1.0 = 0x0200):
- Single beat: a=0x0300 (1.5), b=0x0400 (2.0), idx=2, last=1 → after 3 edges out_data=0x0600, out_idx=2, out_sat=0; bank 2 = 0.
- Accumulate: 4 beats a=b=0x0200 to idx 3, last on the 4th, with interleaved beats to idx 5 (last=0) → out_data=0x0800, out_idx=3; a later last on idx 5 returns only idx 5's sum.
- Saturation:
  - a=b=0x7800 (60.0) → out_data=0x7FFF, out_sat=1.
  - a=0xC000 (-32.0), b=0x1000 (8.0) → out_data=0x8000, out_sat=1.
- Rounding ties:
  - a=0x0001, b=0x0100 (+2^-10) → out_data=0x0001.
  - a=0xFFFF, b=0x0100 (-2^-10) → out_data=0x0000.
- Backpressure: out_ready=0 with a result pending → in_ready=0 next cycle, out_data stable over 5 cycles; out_ready=1 → results drain in order at 1/cycle, no beat lost or duplicated.
- Clear and reset:
  - clr_all one cycle after a non-last beat → a later last on the same idx returns only the post-clear beats.
  - rst_n low mid-stream → out_valid=0 asynchronously, all banks read 0 afterwards.
